// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC      = 32'd4;

  function automatic logic [31:0] align_word(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory req/ack read port.
interface if_fetch_unit_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/fetch_perf_counters.sv
// Wrapping event counters for the fetch stage (FETCH_PERF_EN builds only).
module fetch_perf_counters (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        inc_fetch,
  input  logic        inc_wait,
  input  logic        inc_flush,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_wait_cycles,
  output logic [31:0] perf_flushes
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      perf_fetches     <= '0;
      perf_wait_cycles <= '0;
      perf_flushes     <= '0;
    end else begin
      if (inc_fetch) perf_fetches <= perf_fetches + 32'd1;
      if (inc_wait)  perf_wait_cycles <= perf_wait_cycles + 32'd1;
      if (inc_flush) perf_flushes <= perf_flushes + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction fetch stage: imem req/ack, IF/ID register, next-PC select.
// Optional perf counters under FETCH_PERF_EN.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc_addr,
  output logic [31:0] next_pc,
  output logic        fetch_stall,
  input  logic        hazard_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  if_fetch_unit_if.master imem,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_wait_cycles,
  output logic [31:0] perf_flushes
`endif
);

  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_HOLD  = HOLD;

  logic [1:0]  state, state_d;
  logic [31:0] hold_instr, hold_pc;
  logic [31:0] drain_addr;
  logic        ld_mem, ld_buf, bubble;
  logic        cap_hold, cap_drain;
  logic        is_fetch, is_hold;

  assign is_fetch = (state == S_FETCH);
  assign is_hold  = (state == S_HOLD);

  // Request withdrawn as soon as reset asserts.
  assign imem.req  = Reset & ~is_hold;
  assign imem.addr = (is_fetch | is_hold) ? align_word(pc_addr)
                                          : drain_addr;

  always_comb begin
    state_d     = state;
    next_pc     = pc_addr + PC_INC;
    fetch_stall = 1'b1;
    ld_mem      = 1'b0;
    ld_buf      = 1'b0;
    bubble      = 1'b0;
    cap_hold    = 1'b0;
    cap_drain   = 1'b0;
    if (redirect_valid) begin
      next_pc     = redirect_target;
      fetch_stall = 1'b0;
      unique case (1'b1)
        is_fetch: begin
          if (!imem.ack) begin
            cap_drain = 1'b1;
            state_d   = DRAIN;
          end
        end
        is_hold: state_d = FETCH;
        default: if (imem.ack) state_d = FETCH;
      endcase
    end else begin
      unique case (1'b1)
        is_fetch: begin
          if (imem.ack) begin
            if (!hazard_stall) begin
              ld_mem      = 1'b1;
              fetch_stall = 1'b0;
            end else begin
              cap_hold = 1'b1;
              state_d  = HOLD;
            end
          end else if (!hazard_stall) begin
            bubble = 1'b1;
          end
        end
        is_hold: begin
          if (!hazard_stall) begin
            ld_buf      = 1'b1;
            next_pc     = hold_pc + PC_INC;
            fetch_stall = 1'b0;
            state_d     = FETCH;
          end
        end
        default: begin
          bubble = 1'b1;
          if (imem.ack) state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_FETCH;
      hold_instr <= '0;
      hold_pc    <= '0;
      drain_addr <= '0;
    end else begin
      state <= state_d;
      if (cap_hold) begin
        hold_instr <= imem.rdata;
        hold_pc    <= pc_addr;
      end
      if (cap_drain) drain_addr <= align_word(pc_addr);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= '0;
      ifid_pc4   <= '0;
    end else if (redirect_valid) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (ld_mem) begin
      ifid_valid <= 1'b1;
      ifid_instr <= imem.rdata;
      ifid_pc    <= pc_addr;
      ifid_pc4   <= pc_addr + PC_INC;
    end else if (ld_buf) begin
      ifid_valid <= 1'b1;
      ifid_instr <= hold_instr;
      ifid_pc    <= hold_pc;
      ifid_pc4   <= hold_pc + PC_INC;
    end else if (bubble) begin
      ifid_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .Clk              (Clk),
    .Reset            (Reset),
    .inc_fetch        (ld_mem | ld_buf),
    .inc_wait         (imem.req & ~imem.ack),
    .inc_flush        (redirect_valid),
    .perf_fetches     (perf_fetches),
    .perf_wait_cycles (perf_wait_cycles),
    .perf_flushes     (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic [31:0] pc_addr;
  logic [31:0] next_pc;
  logic        fetch_stall;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_wait_cycles;
  logic [31:0] perf_flushes;
`endif

  int n_chk;
  int n_fail;

  if_fetch_unit_if imem ();

  if_fetch_unit dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .pc_addr         (pc_addr),
    .next_pc         (next_pc),
    .fetch_stall     (fetch_stall),
    .hazard_stall    (hazard_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem            (imem),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pc4        (ifid_pc4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetches     (perf_fetches),
    .perf_wait_cycles (perf_wait_cycles),
    .perf_flushes     (perf_flushes)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic ack,
                       input logic [31:0] rd, input logic hz,
                       input logic rv, input logic [31:0] rt);
    pc_addr         = pc;
    imem.ack        = ack;
    imem.rdata      = rd;
    hazard_stall    = hz;
    redirect_valid  = rv;
    redirect_target = rt;
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if (imem.req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: got %b want 0", imem.req);
    end
    n_chk++;
    if (ifid_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", ifid_valid);
    end
    n_chk++;
    if (ifid_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_instr: got %h want 0", ifid_instr);
    end
    n_chk++;
    if (ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h/%h want 0/0", ifid_pc, ifid_pc4);
    end
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pc;
      logic [31:0] rd;
      pc = 32'h3000 + 32'(4 * i);
      rd = 32'hA000_0000 + 32'(i);
      drive(pc, 1'b1, rd, 1'b0, 1'b0, 32'h0);
      #1;
      n_chk++;
      if (next_pc !== pc + 32'd4 || fetch_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL zw_next %0d: got %h/%b want %h/0",
                 i, next_pc, fetch_stall, pc + 32'd4);
      end
      n_chk++;
      if (imem.req !== 1'b1 || imem.addr !== pc) begin
        n_fail++;
        $display("FAIL zw_req %0d: got %b/%h want 1/%h",
                 i, imem.req, imem.addr, pc);
      end
      tick();
      n_chk++;
      if (ifid_valid !== 1'b1 || ifid_instr !== rd ||
          ifid_pc !== pc || ifid_pc4 !== pc + 32'd4) begin
        n_fail++;
        $display("FAIL zw_ifid %0d: got %b %h %h %h want 1 %h %h %h",
                 i, ifid_valid, ifid_instr, ifid_pc, ifid_pc4,
                 rd, pc, pc + 32'd4);
      end
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      drive(32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      n_chk++;
      if (fetch_stall !== 1'b1 || imem.addr !== 32'h3000) begin
        n_fail++;
        $display("FAIL ws_stall %0d: got %b/%h want 1/00003000",
                 i, fetch_stall, imem.addr);
      end
      tick();
      n_chk++;
      if (ifid_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ws_bubble %0d: got %b want 0", i, ifid_valid);
      end
    end
    drive(32'h3000, 1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (fetch_stall !== 1'b0 || next_pc !== 32'h3004) begin
      n_fail++;
      $display("FAIL ws_ack: got %b/%h want 0/00003004",
               fetch_stall, next_pc);
    end
    tick();
    n_chk++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'hB000_0000) begin
      n_fail++;
      $display("FAIL ws_load: got %b/%h want 1/b0000000",
               ifid_valid, ifid_instr);
    end
  endtask

  task automatic test_hazard_hold();
    drive(32'h3004, 1'b1, 32'hC000_0000, 1'b1, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (fetch_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL hz_stall0: got %b want 1", fetch_stall);
    end
    tick();
    drive(32'h3004, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (imem.req !== 1'b0 || fetch_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL hz_hold: got req %b stall %b want 0/1",
               imem.req, fetch_stall);
    end
    n_chk++;
    if (ifid_instr !== 32'hB000_0000 || ifid_pc !== 32'h3000) begin
      n_fail++;
      $display("FAIL hz_ifid_kept: got %h/%h want b0000000/00003000",
               ifid_instr, ifid_pc);
    end
    tick();
    drive(32'h3004, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (fetch_stall !== 1'b0 || next_pc !== 32'h3008) begin
      n_fail++;
      $display("FAIL hz_release: got %b/%h want 0/00003008",
               fetch_stall, next_pc);
    end
    tick();
    n_chk++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'hC000_0000 ||
        ifid_pc !== 32'h3004 || ifid_pc4 !== 32'h3008) begin
      n_fail++;
      $display("FAIL hz_load: got %b %h %h %h want 1 c0000000 3004 3008",
               ifid_valid, ifid_instr, ifid_pc, ifid_pc4);
    end
  endtask

  task automatic test_redirect();
    drive(32'h3008, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3100);
    #1;
    n_chk++;
    if (next_pc !== 32'h3100 || fetch_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_next: got %h/%b want 00003100/0",
               next_pc, fetch_stall);
    end
    tick();
    n_chk++;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_flush: got %b/%h want 0/00000000",
               ifid_valid, ifid_instr);
    end
    drive(32'h3100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h3008 ||
        fetch_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_drain: got %b %h %b want 1 00003008 1",
               imem.req, imem.addr, fetch_stall);
    end
    tick();
    drive(32'h3100, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (imem.addr !== 32'h3008 || fetch_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_drain_ack: got %h/%b want 00003008/1",
               imem.addr, fetch_stall);
    end
    tick();
    n_chk++;
    if (ifid_valid !== 1'b0 || ifid_instr === 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rd_discard: got %b/%h want 0/not deadbeef",
               ifid_valid, ifid_instr);
    end
    drive(32'h3100, 1'b1, 32'hE000_0000, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (imem.addr !== 32'h3100 || next_pc !== 32'h3104 ||
        fetch_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_refetch: got %h %h %b want 3100 3104 0",
               imem.addr, next_pc, fetch_stall);
    end
    tick();
    n_chk++;
    if (ifid_instr !== 32'hE000_0000 || ifid_pc !== 32'h3100) begin
      n_fail++;
      $display("FAIL rd_load: got %h/%h want e0000000/00003100",
               ifid_instr, ifid_pc);
    end
  endtask

  task automatic test_boundaries();
    drive(32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (next_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: got %h want 00000000", next_pc);
    end
    tick();
    n_chk++;
    if (ifid_pc4 !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_pc4: got %h/%h want fffffffc/00000000",
               ifid_pc, ifid_pc4);
    end
    drive(32'h3002, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (imem.addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL align: got %h want 00003000", imem.addr);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    drive(32'h3010, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3200);
    tick();
    drive(32'h3200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h3010) begin
      n_fail++;
      $display("FAIL mr_drain: got %b/%h want 1/00003010",
               imem.req, imem.addr);
    end
    Reset = 1'b0;
    #1;
    n_chk++;
    if (imem.req !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_req_drop: got %b want 0", imem.req);
    end
    n_chk++;
    if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 ||
        ifid_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL mr_ifid: got %b %h %h want 0 0 0",
               ifid_valid, ifid_pc, ifid_instr);
    end
    tick();
    Reset = 1'b1;
    drive(32'h3000, 1'b1, 32'hF000_0000, 1'b0, 1'b0, 32'h0);
    #1;
    n_chk++;
    if (imem.addr !== 32'h3000 || next_pc !== 32'h3004 ||
        fetch_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_restart: got %h %h %b want 3000 3004 0",
               imem.addr, next_pc, fetch_stall);
    end
    tick();
    n_chk++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'hF000_0000 ||
        ifid_pc !== 32'h3000) begin
      n_fail++;
      $display("FAIL mr_load: got %b %h %h want 1 f0000000 3000",
               ifid_valid, ifid_instr, ifid_pc);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    Reset  = 1'b0;
    drive(32'h3000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_hazard_hold();
    test_redirect();
    test_boundaries();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
